// File: rtl/oled_i2c_target.sv
// -----------------------------------------------------------------------------
// oled_i2c_target
//
// Write-only I2C target for SSD1306-style OLED traffic. It oversamples SCL and
// SDA on clk, detects START/STOP, matches the 7-bit address and ACKs. It then
// demuxes the control byte: bit 6 clear selects the command stream, bit 6 set
// selects the framebuffer data stream.
//
// Parameters
//   ADDRESS   7-bit target address matched in the address byte
//   FB_AW     framebuffer address width
//
// Ports
//   clk        system clock, at least 8x the SCL rate
//   rst_n      asynchronous active-low reset
//   scl        I2C clock pin (input only, no clock stretching)
//   sda_in     I2C data pin as seen on the bus
//   sda_oe     1 = pull SDA low (ACK), 0 = release (open-drain pad)
//   cmd_byte   last received command byte
//   cmd_valid  1-cycle strobe, cmd_byte valid
//   fb_wdata   received display data byte
//   fb_waddr   framebuffer write address
//   fb_we      1-cycle framebuffer write strobe
//   busy       high from address match until STOP or address mismatch
//
// Build option
//   OLED_I2C_TARGET_GLITCH_FILTER_EN: when defined, a 3-tap majority filter
//   sits after the synchronisers on SCL and SDA, so 1-clk pulses are rejected
//   and pin events are acted on 5 clk after the pin change (3 clk without).
// -----------------------------------------------------------------------------
module oled_i2c_target #(
  parameter logic [6:0] ADDRESS = 7'h3C,
  parameter int         FB_AW   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl,
  input  logic             sda_in,
  output logic             sda_oe,
  output logic [7:0]       cmd_byte,
  output logic             cmd_valid,
  output logic [7:0]       fb_wdata,
  output logic [FB_AW-1:0] fb_waddr,
  output logic             fb_we,
  output logic             busy
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_ADDR_ACK = 3'd2;
  localparam logic [2:0] S_CTRL     = 3'd3;
  localparam logic [2:0] S_CTRL_ACK = 3'd4;
  localparam logic [2:0] S_BYTE     = 3'd5;
  localparam logic [2:0] S_BYTE_ACK = 3'd6;
  localparam logic [2:0] S_IGNORE   = 3'd7;

  logic [1:0]       scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic             scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
  logic             scl_f, sda_f;
  logic [2:0]       state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             mode_q, mode_d;
  logic [FB_AW-1:0] ptr_q, ptr_d;
  logic             sda_oe_q, sda_oe_d, busy_q, busy_d;
  logic             cmd_valid_q, cmd_valid_d, fb_we_q, fb_we_d;
  logic [7:0]       cmd_byte_q, cmd_byte_d, fb_wdata_q, fb_wdata_d;
  logic [FB_AW-1:0] fb_waddr_q, fb_waddr_d;
  logic             scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]       byte_in;

`ifdef OLED_I2C_TARGET_GLITCH_FILTER_EN
  // Majority of the current and two previous synchronised samples; a value
  // must persist for 2 clk before it reaches the filtered output.
  logic [1:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
  logic       scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;

  always_comb begin
    scl_hist_d = {scl_hist_q[0], scl_sync_q[1]};
    sda_hist_d = {sda_hist_q[0], sda_sync_q[1]};
    scl_filt_d = (scl_sync_q[1] & scl_hist_q[0]) | (scl_sync_q[1] & scl_hist_q[1]) |
                 (scl_hist_q[0] & scl_hist_q[1]);
    sda_filt_d = (sda_sync_q[1] & sda_hist_q[0]) | (sda_sync_q[1] & sda_hist_q[1]) |
                 (sda_hist_q[0] & sda_hist_q[1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      scl_filt_q <= scl_filt_d;
      sda_filt_q <= sda_filt_d;
    end
  end

  assign scl_f = scl_filt_q;
  assign sda_f = sda_filt_q;
`else
  assign scl_f = scl_sync_q[1];
  assign sda_f = sda_sync_q[1];
`endif

  // Edge and bus-condition detection on the (optionally filtered) pins.
  // START/STOP require SCL high on both the previous and current sample so
  // that an SDA change coinciding with an SCL edge is never misread.
  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl};
    sda_sync_d = {sda_sync_q[0], sda_in};
    scl_prev_d = scl_f;
    sda_prev_d = sda_f;
    scl_rise   = scl_f & ~scl_prev_q;
    scl_fall   = ~scl_f & scl_prev_q;
    start_det  = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
    stop_det   = scl_f & scl_prev_q & ~sda_prev_q & sda_f;
    byte_in    = {shift_q[6:0], sda_f};
  end

  // Main protocol FSM. STOP and START override every state; the ACK states
  // assert sda_oe on the first SCL fall and release it on the next one.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    mode_d      = mode_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    cmd_byte_d  = cmd_byte_q;
    cmd_valid_d = 1'b0;
    fb_wdata_d  = fb_wdata_q;
    fb_waddr_d  = fb_waddr_q;
    fb_we_d     = 1'b0;
    if (stop_det) begin
      state_d   = S_IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 3'd0;
    end else if (start_det) begin
      state_d   = S_ADDR;
      sda_oe_d  = 1'b0;
      bit_cnt_d = 3'd0;
    end else begin
      case (state_q)
        S_ADDR, S_CTRL, S_BYTE: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == S_ADDR) begin
                if (byte_in[7:1] == ADDRESS && !byte_in[0]) begin
                  state_d = S_ADDR_ACK;
                  busy_d  = 1'b1;
                end else begin
                  state_d = S_IGNORE;
                  busy_d  = 1'b0;
                end
              end else if (state_q == S_CTRL) begin
                mode_d  = byte_in[6];
                state_d = S_CTRL_ACK;
              end else begin
                state_d = S_BYTE_ACK;
                if (mode_q) begin
                  fb_we_d    = 1'b1;
                  fb_wdata_d = byte_in;
                  fb_waddr_d = ptr_q;
                  ptr_d      = ptr_q + FB_AW'(1);
                end else begin
                  cmd_valid_d = 1'b1;
                  cmd_byte_d  = byte_in;
                  // Column address set restarts the framebuffer pointer.
                  if (byte_in == 8'h21) ptr_d = '0;
                end
              end
            end
          end
        end
        S_ADDR_ACK, S_CTRL_ACK, S_BYTE_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = (state_q == S_ADDR_ACK) ? S_CTRL : S_BYTE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q  <= 2'b11;
      sda_sync_q  <= 2'b11;
      scl_prev_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      mode_q      <= 1'b0;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      cmd_byte_q  <= 8'h00;
      cmd_valid_q <= 1'b0;
      fb_wdata_q  <= 8'h00;
      fb_waddr_q  <= '0;
      fb_we_q     <= 1'b0;
    end else begin
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      scl_prev_q  <= scl_prev_d;
      sda_prev_q  <= sda_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      mode_q      <= mode_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      cmd_byte_q  <= cmd_byte_d;
      cmd_valid_q <= cmd_valid_d;
      fb_wdata_q  <= fb_wdata_d;
      fb_waddr_q  <= fb_waddr_d;
      fb_we_q     <= fb_we_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign cmd_byte  = cmd_byte_q;
  assign cmd_valid = cmd_valid_q;
  assign fb_wdata  = fb_wdata_q;
  assign fb_waddr  = fb_waddr_q;
  assign fb_we     = fb_we_q;

endmodule

// File: tb/tb_oled_i2c_target.sv
// -----------------------------------------------------------------------------
// tb_oled_i2c_target
//
// Bit-banged I2C master driving oled_i2c_target over an open-drain SDA model.
// A transaction-level reference model predicts the ACK of every byte, the busy
// flag and the ordered list of cmd/framebuffer strobes; a monitor collects the
// strobes the target actually produces. A small framebuffer (FB_AW = 5) keeps
// pointer wrap-around reachable in a short run.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_oled_i2c_target;

  localparam int FB_AW = 5;
  localparam int DEPTH = 1 << FB_AW;
  localparam int Q     = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             scl_m = 1'b1;
  logic             sda_m = 1'b1;
  logic             sda_line;
  logic             sda_oe;
  logic [7:0]       cmd_byte;
  logic             cmd_valid;
  logic [7:0]       fb_wdata;
  logic [FB_AW-1:0] fb_waddr;
  logic             fb_we;
  logic             busy;

  // Open-drain bus: either side may pull SDA low.
  assign sda_line = sda_m & ~sda_oe;

  oled_i2c_target #(.ADDRESS(7'h3C), .FB_AW(FB_AW)) dut (
    .clk(clk), .rst_n(rst_n), .scl(scl_m), .sda_in(sda_line), .sda_oe(sda_oe),
    .cmd_byte(cmd_byte), .cmd_valid(cmd_valid), .fb_wdata(fb_wdata),
    .fb_waddr(fb_waddr), .fb_we(fb_we), .busy(busy)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int rule_viol = 0;
  logic strobe_prev = 1'b0;
  logic glitch_now = 1'b0;
  logic [31:0] obs_q[$];
  logic [31:0] exp_q[$];
  logic [7:0] xfer_bytes [8];
  int xfer_len;
  int ref_ptr = 0;
  int ref_mode = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Event word: kind (1 = command, 2 = framebuffer write), data, address.
  function automatic logic [31:0] mk_ev(input int kind, input logic [7:0] d, input int a);
    return {8'(kind), d, 16'(a)};
  endfunction

  // Strobe monitor, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid) obs_q.push_back(mk_ev(1, cmd_byte, 0));
      if (fb_we) obs_q.push_back(mk_ev(2, fb_wdata, int'(fb_waddr)));
      if ((cmd_valid && fb_we) || ((cmd_valid || fb_we) && strobe_prev)) rule_viol++;
      strobe_prev = cmd_valid || fb_we;
    end else begin
      strobe_prev = 1'b0;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(2 * Q);
  endtask

  // Optional 1-clk inverted pulse on SDA in the middle of the SCL high phase.
  task automatic i2c_bit(input logic b);
    sda_m = b; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    if (glitch_now) begin
      sda_m = ~b; wait_clk(1);
      sda_m = b;  wait_clk(Q - 1);
    end else begin
      wait_clk(Q);
    end
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_ack(output logic ack);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    ack = ~sda_line;
    wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input int nbits, output logic ack);
    ack = 1'b0;
    for (int i = 0; i < nbits; i++) i2c_bit(b[7 - i]);
    if (nbits == 8) i2c_ack(ack);
  endtask

  task automatic compare_events(input string tag);
    int n;
    wait_clk(4);
    checkOutput({tag, " strobe_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s ev%0d", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  // One transaction: START, xfer_bytes[0..xfer_len-1], optional partial byte,
  // then STOP (or nothing, leaving the next START as a repeated START).
  task automatic applyStimulus(input string tag, input int partial_bits, input logic end_stop);
    logic ack;
    logic matched;
    logic [7:0] b;
    matched = (xfer_bytes[0] == 8'h78);
    i2c_start();
    for (int k = 0; k < xfer_len; k++) begin
      b = xfer_bytes[k];
      send_byte(b, 8, ack);
      checkOutput($sformatf("%s ack%0d", tag, k), 32'(ack), 32'(matched));
      if (k == 0) checkOutput({tag, " busy_addr"}, 32'(busy), 32'(matched));
      if (matched && k == 1) ref_mode = (b[6] == 1'b1) ? 1 : 0;
      if (matched && k >= 2) begin
        if (ref_mode == 0) begin
          exp_q.push_back(mk_ev(1, b, 0));
          if (b == 8'h21) ref_ptr = 0;
        end else begin
          exp_q.push_back(mk_ev(2, b, ref_ptr));
          ref_ptr = (ref_ptr + 1) % DEPTH;
        end
      end
    end
    if (partial_bits > 0) send_byte(8'($urandom), partial_bits, ack);
    if (end_stop) begin
      i2c_stop();
      wait_clk(8);
      checkOutput({tag, " busy_stop"}, 32'(busy), 32'd0);
    end
    compare_events(tag);
  endtask

  initial begin
    logic dummy;
    // Reset values.
    wait_clk(3);
    checkOutput("rst sda_oe", 32'(sda_oe), 32'd0);
    checkOutput("rst cmd_valid", 32'(cmd_valid), 32'd0);
    checkOutput("rst fb_we", 32'(fb_we), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst cmd_byte", 32'(cmd_byte), 32'd0);
    checkOutput("rst fb_wdata", 32'(fb_wdata), 32'd0);
    checkOutput("rst fb_waddr", 32'(fb_waddr), 32'd0);
    rst_n = 1'b1;
    wait_clk(4);

    // Single command.
    xfer_bytes[0] = 8'h78; xfer_bytes[1] = 8'h00; xfer_bytes[2] = 8'hAE; xfer_len = 3;
    applyStimulus("cmd", 0, 1'b1);
    // Three data bytes.
    xfer_bytes[1] = 8'h40; xfer_bytes[2] = 8'h11; xfer_bytes[3] = 8'h22; xfer_bytes[4] = 8'h33;
    xfer_len = 5;
    applyStimulus("data", 0, 1'b1);
    // Wrong address.
    xfer_bytes[0] = 8'h7A; xfer_bytes[1] = 8'h00; xfer_bytes[2] = 8'hAE; xfer_len = 3;
    applyStimulus("badaddr", 0, 1'b1);
    // Read request, then repeated START with column-address command.
    xfer_bytes[0] = 8'h79; xfer_len = 1;
    applyStimulus("read", 0, 1'b0);
    xfer_bytes[0] = 8'h78; xfer_bytes[1] = 8'h00; xfer_bytes[2] = 8'h21; xfer_len = 3;
    applyStimulus("colset", 0, 1'b1);
    xfer_bytes[1] = 8'h40; xfer_bytes[2] = 8'h55; xfer_len = 3;
    applyStimulus("ptr0", 0, 1'b1);

    // Fill past the end of the framebuffer to cross the wrap point.
    for (int t = 0; t < 7; t++) begin
      xfer_bytes[0] = 8'h78; xfer_bytes[1] = 8'h40;
      for (int k = 2; k < 7; k++) xfer_bytes[k] = 8'($urandom);
      xfer_len = 7;
      applyStimulus($sformatf("wrap%0d", t), 0, 1'b1);
    end
    // STOP after 4 bits of a data byte.
    xfer_bytes[0] = 8'h78; xfer_bytes[1] = 8'h40; xfer_bytes[2] = 8'hAA; xfer_len = 3;
    applyStimulus("partial", 4, 1'b1);

    // Randomised transactions.
    for (int t = 0; t < 15; t++) begin
      int sel;
      int plen;
      sel = $urandom_range(0, 9);
      xfer_bytes[0] = (sel <= 6) ? 8'h78 : (sel == 7) ? 8'h79 : (sel == 8) ? 8'h7A : 8'($urandom);
      xfer_bytes[1] = 8'($urandom);
      plen = $urandom_range(0, 4);
      for (int k = 2; k < 2 + plen; k++)
        xfer_bytes[k] = ($urandom_range(0, 5) == 0) ? 8'h21 : 8'($urandom);
      xfer_len = (xfer_bytes[0] == 8'h79) ? 1 : 2 + plen;
      applyStimulus($sformatf("rnd%0d", t), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0,
                    ($urandom_range(0, 4) != 0));
    end

    // Reset asserted while the target is driving the address ACK.
    i2c_start();
    for (int i = 0; i < 8; i++) i2c_bit(8'h78 >> (7 - i) & 8'h01 ? 1'b1 : 1'b0);
    wait_clk(2);
    checkOutput("ack_driven", 32'(sda_oe), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid sda_oe", 32'(sda_oe), 32'd0);
    checkOutput("rst_mid busy", 32'(busy), 32'd0);
    checkOutput("rst_mid fb_waddr", 32'(fb_waddr), 32'd0);
    scl_m = 1'b1; sda_m = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    ref_ptr = 0; ref_mode = 0;
    obs_q.delete(); exp_q.delete();
    wait_clk(4);
    xfer_bytes[0] = 8'h78; xfer_bytes[1] = 8'h40; xfer_bytes[2] = 8'h9C; xfer_len = 3;
    applyStimulus("after_rst", 0, 1'b1);

`ifdef OLED_I2C_TARGET_GLITCH_FILTER_EN
    // Every data bit carries a 1-clk SDA pulse while SCL is high; the filter
    // must hide them all, so no spurious START/STOP disturbs the transfer.
    glitch_now = 1'b1;
    xfer_bytes[0] = 8'h78; xfer_bytes[1] = 8'h40; xfer_bytes[2] = 8'h5A; xfer_bytes[3] = 8'hC3;
    xfer_len = 4;
    applyStimulus("glitch", 0, 1'b1);
    glitch_now = 1'b0;
`endif

    dummy = 1'b0;
    checkOutput("strobe_rules", 32'(rule_viol), 32'(dummy));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
